// File: rtl/host_reset_pkg.sv
// Shared types and helpers for the host reset sequencer.
// Holds the FSM state encoding, the diagnostic counter width and a width helper.
package host_reset_pkg;

   typedef enum logic [1:0] {
      StWaitLock = 2'd0,
      StHold     = 2'd1,
      StRelease  = 2'd2,
      StRun      = 2'd3
   } state_e;

   localparam int unsigned LOST_CNT_W = 16;

   // Counter width for a modulus, never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/lock_sync.sv
// Single-bit synchroniser chain for an asynchronous lock indication.
// Synchronous active-low clear drives every flop in the chain to zero.
module lock_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/host_reset_sequencer.sv
// Staged reset release gated on synchronised clock-generator locks.
// Re-asserts every stage on lock loss or software request and counts lock losses.
module host_reset_sequencer
   import host_reset_pkg::*;
#(
   parameter int unsigned NUM_LOCKS   = 1,
   parameter int unsigned NUM_STAGES  = 2,
   parameter int unsigned HOLD_CYCLES = 64,
   parameter int unsigned STAGE_GAP   = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [NUM_LOCKS-1:0]  lock_in,
   input  logic                  sw_reset_req,
   output logic [NUM_STAGES-1:0] stage_reset_n,
   output logic                  all_released,
   output logic [LOST_CNT_W-1:0] lock_lost_count,
   output logic [1:0]            state
);

   localparam int unsigned HoldW = clog2_min1(HOLD_CYCLES);
   localparam int unsigned GapW  = clog2_min1(STAGE_GAP);
   localparam int unsigned IdxW  = clog2_min1(NUM_STAGES);

   localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
   localparam logic [GapW-1:0]  GapLast  = GapW'(STAGE_GAP - 1);
   localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_STAGES - 1);

   logic [NUM_LOCKS-1:0] lock_sync_vec;
   logic                 locks_ok;

   for (genvar g = 0; g < NUM_LOCKS; g++) begin : g_lock_sync
      lock_sync #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_lock_sync (
         .clk_i (clock),
         .rst_ni(reset_n),
         .d_i   (lock_in[g]),
         .q_o   (lock_sync_vec[g])
      );
   end

   assign locks_ok = &lock_sync_vec;

   state_e                  state_q, state_d;
   logic [HoldW-1:0]        hold_cnt_q, hold_cnt_d;
   logic [GapW-1:0]         gap_cnt_q, gap_cnt_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic [NUM_STAGES-1:0]   stage_q, stage_d;
   logic                    all_rel_q, all_rel_d;
   logic [LOST_CNT_W-1:0]   lost_cnt_q, lost_cnt_d;

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      idx_d      = idx_q;
      stage_d    = stage_q;
      all_rel_d  = all_rel_q;
      lost_cnt_d = lost_cnt_q;

      case (state_q)
         StWaitLock: begin
            stage_d   = '0;
            all_rel_d = 1'b0;
            if (locks_ok) begin
               state_d    = StHold;
               hold_cnt_d = '0;
            end
         end

         StHold: begin
            // Losing lock before release is not a diagnostic event.
            if (!locks_ok) begin
               state_d = StWaitLock;
            end else if (hold_cnt_q == HoldLast) begin
               stage_d   = NUM_STAGES'(1);
               gap_cnt_d = '0;
               idx_d     = '0;
               if (NUM_STAGES == 1) begin
                  state_d   = StRun;
                  all_rel_d = 1'b1;
               end else begin
                  state_d = StRelease;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end

         StRelease, StRun: begin
            if (!locks_ok) begin
               state_d   = StWaitLock;
               stage_d   = '0;
               all_rel_d = 1'b0;
               if (lost_cnt_q != '1) begin
                  lost_cnt_d = lost_cnt_q + 1'b1;
               end
            end else if (sw_reset_req) begin
               state_d    = StHold;
               hold_cnt_d = '0;
               stage_d    = '0;
               all_rel_d  = 1'b0;
            end else if (state_q == StRelease) begin
               if (gap_cnt_q == GapLast) begin
                  gap_cnt_d = '0;
                  idx_d     = idx_q + 1'b1;
                  // Stages form a thermometer code, so the next one up joins.
                  stage_d   = (stage_q << 1) | NUM_STAGES'(1);
                  if (idx_d == IdxLast) begin
                     state_d   = StRun;
                     all_rel_d = 1'b1;
                  end
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end
         end

         default: begin
            state_d   = StWaitLock;
            stage_d   = '0;
            all_rel_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= StWaitLock;
         hold_cnt_q <= '0;
         gap_cnt_q  <= '0;
         idx_q      <= '0;
         stage_q    <= '0;
         all_rel_q  <= 1'b0;
         lost_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         idx_q      <= idx_d;
         stage_q    <= stage_d;
         all_rel_q  <= all_rel_d;
         lost_cnt_q <= lost_cnt_d;
      end
   end

   assign stage_reset_n   = stage_q;
   assign all_released    = all_rel_q;
   assign lock_lost_count = lost_cnt_q;
   assign state           = state_q;

endmodule

// File: tb/tb_host_reset_sequencer.sv
// Bench for host_reset_sequencer: directed bring-up/abort scenarios plus random
// lock/request traffic, all checked against an elapsed-time reference model.
module tb_host_reset_sequencer;

   localparam int NL = 2;
   localparam int NS = 3;
   localparam int HC = 8;
   localparam int SG = 4;
   localparam int SS = 2;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [NL-1:0] lock_in;
   logic          sw_reset_req;
   logic [NS-1:0] stage_reset_n;
   logic          all_released;
   logic [15:0]   lock_lost_count;
   logic [1:0]    state;

   always #5 clock = ~clock;

   host_reset_sequencer #(
      .NUM_LOCKS  (NL),
      .NUM_STAGES (NS),
      .HOLD_CYCLES(HC),
      .STAGE_GAP  (SG),
      .SYNC_STAGES(SS)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .lock_in        (lock_in),
      .sw_reset_req   (sw_reset_req),
      .stage_reset_n  (stage_reset_n),
      .all_released   (all_released),
      .lock_lost_count(lock_lost_count),
      .state          (state)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cycle   = 0;

   // Reference model: m_el counts edges spent locked since the hold window began;
   // stage k is released once m_el reaches HC + k*SG.
   logic [NL-1:0] m_sync [SS];
   bit            m_wait;
   int            m_el;
   int            m_cnt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
      end
   endtask

   function automatic int m_released();
      int n;
      if (m_wait || m_el < HC) return 0;
      n = 1 + (m_el - HC) / SG;
      return (n < NS) ? n : NS;
   endfunction

   task automatic model_edge();
      logic ok;
      ok = &m_sync[SS-1];
      for (int i = SS - 1; i > 0; i--) m_sync[i] = reset_n ? m_sync[i-1] : '0;
      m_sync[0] = reset_n ? lock_in : '0;
      if (!reset_n) begin
         m_wait = 1'b1;
         m_el   = 0;
         m_cnt  = 0;
      end else if (m_wait) begin
         if (ok) begin
            m_wait = 1'b0;
            m_el   = 0;
         end
      end else if (!ok) begin
         if (m_el >= HC) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
         m_wait = 1'b1;
      end else if (sw_reset_req && m_el >= HC) begin
         m_el = 0;
      end else if (m_el < HC + (NS - 1) * SG) begin
         m_el++;
      end
   endtask

   task automatic check_outputs(input string tag);
      int n;
      int exp_state;
      n = m_released();
      if (m_wait)        exp_state = 0;
      else if (m_el < HC) exp_state = 1;
      else if (n < NS)   exp_state = 2;
      else               exp_state = 3;
      check_eq({tag, ".stage"}, 32'(stage_reset_n), 32'((1 << n) - 1));
      check_eq({tag, ".all"},   32'(all_released),  32'(n == NS));
      check_eq({tag, ".state"}, 32'(state),         32'(exp_state));
      check_eq({tag, ".count"}, 32'(lock_lost_count), 32'(m_cnt));
   endtask

   task automatic tick(input string tag);
      @(posedge clock);
      model_edge();
      #1;
      cycle++;
      check_outputs(tag);
   endtask

   initial begin
      reset_n      = 1'b0;
      lock_in      = '1;
      sw_reset_req = 1'b0;
      for (int i = 0; i < SS; i++) m_sync[i] = '0;
      m_wait = 1'b1;
      m_el   = 0;
      m_cnt  = 0;

      // Reset state
      repeat (3) tick("reset");
      check_eq("rst_stage", 32'(stage_reset_n), 32'd0);
      check_eq("rst_state", 32'(state), 32'd0);
      check_eq("rst_count", 32'(lock_lost_count), 32'd0);

      // Clean bring-up with edges numbered from the first reset_n=1 edge
      reset_n = 1'b1;
      for (int e = 1; e <= 19; e++) begin
         tick("bringup");
         if (e == 3)  check_eq("bu_hold_e3",   32'(state), 32'd1);
         if (e == 10) check_eq("bu_stage_e10", 32'(stage_reset_n), 32'd0);
         if (e == 11) check_eq("bu_stage_e11", 32'(stage_reset_n), 32'd1);
         if (e == 14) check_eq("bu_stage_e14", 32'(stage_reset_n), 32'd1);
         if (e == 15) check_eq("bu_stage_e15", 32'(stage_reset_n), 32'd3);
         if (e == 18) check_eq("bu_all_e18",   32'(all_released), 32'd0);
         if (e == 19) begin
            check_eq("bu_stage_e19", 32'(stage_reset_n), 32'd7);
            check_eq("bu_all_e19",   32'(all_released), 32'd1);
            check_eq("bu_state_e19", 32'(state), 32'd3);
         end
      end

      // Lock loss in RUN: stages drop exactly three edges later
      lock_in[0] = 1'b0;
      for (int d = 1; d <= 3; d++) begin
         tick("loss");
         if (d == 2) check_eq("loss_stage_d2", 32'(stage_reset_n), 32'd7);
         if (d == 3) begin
            check_eq("loss_stage_d3", 32'(stage_reset_n), 32'd0);
            check_eq("loss_all_d3",   32'(all_released), 32'd0);
            check_eq("loss_count_d3", 32'(lock_lost_count), 32'd1);
         end
      end
      lock_in = '1;
      for (int r = 1; r <= 19; r++) begin
         tick("relock");
         if (r == 10) check_eq("rl_stage_r10", 32'(stage_reset_n), 32'd0);
         if (r == 11) check_eq("rl_stage_r11", 32'(stage_reset_n), 32'd1);
         if (r == 15) check_eq("rl_stage_r15", 32'(stage_reset_n), 32'd3);
         if (r == 19) check_eq("rl_stage_r19", 32'(stage_reset_n), 32'd7);
      end

      // Lock loss and software request land on the same edge
      lock_in[1] = 1'b0;
      repeat (2) tick("simul");
      sw_reset_req = 1'b1;
      tick("simul");
      sw_reset_req = 1'b0;
      check_eq("simul_state", 32'(state), 32'd0);
      check_eq("simul_count", 32'(lock_lost_count), 32'd2);
      lock_in = '1;
      repeat (19) tick("simul_relock");
      check_eq("simul_run", 32'(state), 32'd3);

      // Saturation of the lock-loss counter
      force dut.lost_cnt_q = 16'hFFFF;
      m_cnt = 65535;
      tick("force");
      release dut.lost_cnt_q;
      tick("force");
      lock_in[0] = 1'b0;
      repeat (3) tick("sat");
      check_eq("sat_count", 32'(lock_lost_count), 32'hFFFF);
      check_eq("sat_state", 32'(state), 32'd0);

      // One-cycle glitch on lock_in[1] while hold_cnt == 5
      lock_in = '1;
      for (int e = 1; e <= 20; e++) begin
         if (e == 9)  lock_in[1] = 1'b0;
         if (e == 10) lock_in[1] = 1'b1;
         tick("glitch");
         if (e == 11) check_eq("gl_state_e11", 32'(state), 32'd0);
         if (e == 12) check_eq("gl_state_e12", 32'(state), 32'd1);
         if (e == 19) check_eq("gl_stage_e19", 32'(stage_reset_n), 32'd0);
         if (e == 20) begin
            check_eq("gl_stage_e20", 32'(stage_reset_n), 32'd1);
            check_eq("gl_count_e20", 32'(lock_lost_count), 32'hFFFF);
         end
      end

      // Software request in RELEASE with only stage 0 out
      sw_reset_req = 1'b1;
      tick("swreq");
      sw_reset_req = 1'b0;
      check_eq("sw_stage", 32'(stage_reset_n), 32'd0);
      check_eq("sw_state", 32'(state), 32'd1);
      check_eq("sw_count", 32'(lock_lost_count), 32'hFFFF);
      for (int s = 2; s <= 9; s++) begin
         tick("swreq");
         if (s == 8) check_eq("sw_stage_s8", 32'(stage_reset_n), 32'd0);
         if (s == 9) check_eq("sw_stage_s9", 32'(stage_reset_n), 32'd1);
      end

      // Reset pulse mid-RELEASE
      repeat (5) tick("midrel");
      check_eq("mid_state_pre", 32'(state), 32'd2);
      reset_n = 1'b0;
      tick("midrst");
      reset_n = 1'b1;
      check_eq("mid_stage", 32'(stage_reset_n), 32'd0);
      check_eq("mid_state", 32'(state), 32'd0);
      check_eq("mid_count", 32'(lock_lost_count), 32'd0);
      check_eq("mid_all",   32'(all_released), 32'd0);

      // Random lock traffic, software requests and occasional resets
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < NL; b++) begin
            if (lock_in[b]) begin
               if ($urandom_range(149) == 0) lock_in[b] = 1'b0;
            end else if ($urandom_range(9) == 0) begin
               lock_in[b] = 1'b1;
            end
         end
         sw_reset_req = ($urandom_range(29) == 0);
         reset_n      = ($urandom_range(399) != 0);
         tick("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
